// File: rtl/i2s_tx_out_pkg.sv
// Shared frame constants and the slot bit-index mapping for the I2S output stage.
// The 64-bit frame is two 32-bit slots with the one-bclk I2S data delay.
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int BCNT_W     = 6;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef logic [BCNT_W-1:0] bcnt_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] idx;
    } bit_sel_t;

    // Slot position 0 is the I2S delay bit; positions 1..dsize carry the word MSB first.
    function automatic bit_sel_t bit_select(input bcnt_t b, input int dsize);
        bit_sel_t sel;
        int       pos;
        pos       = int'(b) % SLOT_BITS;
        sel.valid = (pos >= 1) && (pos <= dsize);
        sel.idx   = sel.valid ? 8'(dsize - pos) : 8'd0;
        return sel;
    endfunction

    function automatic logic slot_lrck(input bcnt_t b);
        return (int'(b) >= SLOT_BITS) ? LRCK_RIGHT : LRCK_LEFT;
    endfunction

endpackage

// File: rtl/i2s_tx_out_if.sv
// Sample handshake from the filter plus the I2S/status outputs of the transmitter.
// master = transmitter side, slave = filter/codec/observer side.
interface i2s_tx_out_if #(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                        enable;
    logic                        filter_done;
    logic signed [DATA_SIZE-1:0] data_in;
    logic                        bclk;
    logic                        lrck;
    logic                        sdata;
    logic [LVL_W-1:0]            fifo_level;
    logic                        overflow;
    logic                        underflow;

    modport master (
        input  enable, filter_done, data_in,
        output bclk, lrck, sdata, fifo_level, overflow, underflow
    );

    modport slave (
        output enable, filter_done, data_in,
        input  bclk, lrck, sdata, fifo_level, overflow, underflow
    );

endinterface

// File: rtl/i2s_tx_out_sample_fifo.sv
// Small synchronous show-ahead FIFO for filtered samples.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DATA_SIZE-1:0]              din,
    output logic [DATA_SIZE-1:0]              dout,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH):0]       level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LVL_W-1:0]     count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_reg == LVL_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage has no reset; emptiness is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_out.sv
// Mono I2S master transmitter: buffers filter results and sends each one in both slots.
// All serial outputs change only on bclk falling events so the codec samples on rising.
module i2s_tx_out
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE  = 24,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    i2s_tx_out_if.master bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic                 capture_pending_reg;
    logic [DIV_W-1:0]     div_reg;
    logic                 bclk_reg;
    logic                 lrck_reg;
    logic                 sdata_reg;
    logic                 underflow_reg;
    logic                 started_reg;
    bcnt_t                bcnt_reg;
    logic [DATA_SIZE-1:0] word_reg;
    logic [DATA_SIZE-1:0] last_word_reg;

    logic                 div_wrap;
    logic                 fall_event;
    bcnt_t                bcnt_next;
    logic                 frame_load;
    logic                 sdata_next;
    logic [DATA_SIZE-1:0] load_word;
    logic [DATA_SIZE-1:0] shifted;
    bit_sel_t             sel;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_dout;
    logic [LVL_W-1:0]     fifo_level;

    sample_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The filter's output register is only valid the cycle after its done pulse,
    // so the push is issued from a one-cycle pending flag.
    assign fifo_push = capture_pending_reg;

    always_comb begin
        div_wrap   = bus.enable && (div_reg == DIV_LAST);
        fall_event = div_wrap && bclk_reg;
        // The first falling event after enable always lands on b=0 and loads a frame.
        bcnt_next  = started_reg ? bcnt_reg + 1'b1 : '0;
        frame_load = fall_event && (bcnt_next == '0);
        fifo_pop   = frame_load && !fifo_empty;
        load_word  = fifo_pop ? fifo_dout : last_word_reg;
        sel        = bit_select(bcnt_next, DATA_SIZE);
        shifted    = word_reg >> sel.idx;
        sdata_next = sel.valid & shifted[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capture_pending_reg <= 1'b0;
            div_reg             <= '0;
            bclk_reg            <= 1'b0;
            lrck_reg            <= 1'b0;
            sdata_reg           <= 1'b0;
            underflow_reg       <= 1'b0;
            started_reg         <= 1'b0;
            bcnt_reg            <= '0;
            word_reg            <= '0;
            last_word_reg       <= '0;
        end else begin
            capture_pending_reg <= bus.filter_done;
            underflow_reg       <= 1'b0;
            if (!bus.enable) begin
                div_reg     <= '0;
                bclk_reg    <= 1'b0;
                lrck_reg    <= 1'b0;
                sdata_reg   <= 1'b0;
                started_reg <= 1'b0;
                bcnt_reg    <= '0;
            end else begin
                if (div_wrap) begin
                    div_reg  <= '0;
                    bclk_reg <= ~bclk_reg;
                end else begin
                    div_reg  <= div_reg + 1'b1;
                end
                if (fall_event) begin
                    bcnt_reg    <= bcnt_next;
                    started_reg <= 1'b1;
                    lrck_reg    <= slot_lrck(bcnt_next);
                    // b=0 is a pad bit, so loading the word here never disturbs the line.
                    sdata_reg   <= sdata_next;
                    if (frame_load) begin
                        word_reg      <= load_word;
                        last_word_reg <= load_word;
                        underflow_reg <= fifo_empty;
                    end
                end
            end
        end
    end

    assign bus.bclk       = bclk_reg;
    assign bus.lrck       = lrck_reg;
    assign bus.sdata      = sdata_reg;
    assign bus.underflow  = underflow_reg;
    assign bus.fifo_level = fifo_level;
    assign bus.overflow   = fifo_push && fifo_full && !fifo_pop;

endmodule

// File: tb/tb_i2s_tx_out.sv
// Directed bench for i2s_tx_out with BCLK_DIV=2, FIFO_DEPTH=4.
// Frames are captured bit by bit after each bclk falling edge and decoded back to words.
module tb_i2s_tx_out;

    localparam int DATA_SIZE  = 24;
    localparam int BCLK_DIV   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    i2s_tx_out_if #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    i2s_tx_out #(
        .DATA_SIZE  (DATA_SIZE),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    int               ov_cnt   = 0;
    logic             bclk_last = 1'b0;
    logic [63:0]      sd;
    logic [63:0]      lr;
    logic             uf0;
    logic [LVL_W-1:0] lv0;
    logic [7:0]       acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        bclk_last = bus.bclk;
        @(negedge clk);
        if (bus.overflow === 1'b1) ov_cnt++;
    endtask

    task automatic push_sample(input logic [23:0] decoy, input logic [23:0] val);
        bus.filter_done = 1'b1;
        bus.data_in     = decoy;
        step();
        bus.filter_done = 1'b0;
        bus.data_in     = val;
        step();
    endtask

    task automatic next_bit(output logic s, output logic l, output logic u, output logic [LVL_W-1:0] v);
        bit found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            step();
            if (bclk_last === 1'b1 && bus.bclk === 1'b0) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL bclk_fall: no falling edge within 16 clk");
        end
        s = bus.sdata;
        l = bus.lrck;
        u = bus.underflow;
        v = bus.fifo_level;
    endtask

    task automatic get_frame(input int push_at, input logic [23:0] push_val,
                             output logic [63:0] fsd, output logic [63:0] flr,
                             output logic fuf, output logic [LVL_W-1:0] flv);
        logic s, l, u;
        logic [LVL_W-1:0] v;
        fuf = 1'b0;
        flv = '0;
        for (int i = 0; i < 64; i++) begin
            next_bit(s, l, u, v);
            fsd[i] = s;
            flr[i] = l;
            if (i == 0) begin
                fuf = u;
                flv = v;
            end
            if (i == push_at) push_sample(24'h5A5A5A, push_val);
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] word,
                               input logic [63:0] fsd, input logic [63:0] flr);
        logic [23:0] left, right;
        logic [15:0] pads;
        for (int k = 0; k < 24; k++) begin
            left[23-k]  = fsd[1+k];
            right[23-k] = fsd[33+k];
        end
        pads = {fsd[63:57], fsd[32:25], fsd[0]};
        check({tag, "_left"}, left, word);
        check({tag, "_right"}, right, word);
        check({tag, "_pads"}, pads, 0);
        check({tag, "_lrck"}, flr, 64'hFFFF_FFFF_0000_0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s, l, u;
        logic [LVL_W-1:0] v;

        bus.enable      = 1'b1;
        bus.filter_done = 1'b0;
        bus.data_in     = '0;
        acc             = '0;

        // Reset held with enable high and busy inputs
        for (int i = 0; i < 8; i++) begin
            bus.filter_done = i[0];
            bus.data_in     = 24'(i * 32'h111111);
            step();
            acc |= {bus.bclk, bus.lrck, bus.sdata, bus.overflow, bus.underflow, bus.fifo_level};
        end
        check("reset_outputs", acc, 0);
        bus.filter_done = 1'b0;
        reset = 1'b1;
        step();
        check("bclk_after_1clk", bus.bclk, 0);
        step();
        check("bclk_rise_2clk", bus.bclk, 1);
        bus.enable = 1'b0;
        step();
        step();
        check("disable_bclk", bus.bclk, 0);

        // Single sample; decoy on the done cycle must not be captured
        push_sample(24'h123456, 24'hA50F3C);
        check("level_after_push", bus.fifo_level, 1);
        bus.enable = 1'b1;
        get_frame(-1, 24'h0, sd, lr, uf0, lv0);
        check_frame("f1", 24'hA50F3C, sd, lr);
        check("f1_load_level", lv0, 0);
        check("f1_underflow", uf0, 0);

        // Underflow repeat, with a push mid-frame
        get_frame(40, 24'h800000, sd, lr, uf0, lv0);
        check_frame("f2_repeat", 24'hA50F3C, sd, lr);
        check("f2_underflow", uf0, 1);
        get_frame(-1, 24'h0, sd, lr, uf0, lv0);
        check_frame("f3", 24'h800000, sd, lr);
        check("f3_underflow", uf0, 0);

        // Partial frame with capture-timing push, then disable at b=40
        for (int i = 0; i <= 40; i++) begin
            next_bit(s, l, u, v);
            if (i == 20) push_sample(24'h000001, 24'h7FFFFF);
        end
        check("b40_lrck", l, 1);
        bus.enable = 1'b0;
        step();
        check("disable_outputs", {bus.bclk, bus.lrck, bus.sdata}, 0);
        check("disable_fifo_kept", bus.fifo_level, 1);
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            acc |= {5'b0, bus.bclk, bus.lrck, bus.sdata};
        end
        check("disabled_idle", acc, 0);
        bus.enable = 1'b1;
        get_frame(-1, 24'h0, sd, lr, uf0, lv0);
        check_frame("f_restart", 24'h7FFFFF, sd, lr);
        check("f_restart_underflow", uf0, 0);
        check("f_restart_level", lv0, 0);

        // Overflow: five pushes into a depth-4 FIFO while disabled
        bus.enable = 1'b0;
        step();
        ov_cnt = 0;
        for (int n = 1; n <= 5; n++) begin
            push_sample(24'hFFFFFF, 24'(n));
            step();
            step();
            if (n == 4) begin
                check("ovf_level_4", bus.fifo_level, 4);
                check("ovf_none_yet", ov_cnt, 0);
            end
        end
        check("ovf_level_5", bus.fifo_level, 4);
        check("ovf_pulses", ov_cnt, 1);
        bus.enable = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            get_frame(-1, 24'h0, sd, lr, uf0, lv0);
            check_frame($sformatf("ovf_f%0d", n), 24'(n), sd, lr);
            check($sformatf("ovf_f%0d_level", n), lv0, 64'(4 - n));
        end
        get_frame(-1, 24'h0, sd, lr, uf0, lv0);
        check_frame("ovf_repeat", 24'h000004, sd, lr);
        check("ovf_repeat_underflow", uf0, 1);

        // Asynchronous reset mid-frame with a sample buffered
        for (int i = 0; i <= 10; i++) begin
            next_bit(s, l, u, v);
            if (i == 5) push_sample(24'h5A5A5A, 24'h0000AA);
        end
        step();
        step();
        check("pre_reset_bclk", bus.bclk, 1);
        check("pre_reset_level", bus.fifo_level, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {bus.bclk, bus.lrck, bus.sdata, bus.underflow}, 0);
        check("async_reset_level", bus.fifo_level, 0);
        step();
        step();
        reset = 1'b1;
        get_frame(-1, 24'h0, sd, lr, uf0, lv0);
        check_frame("post_reset", 24'h000000, sd, lr);
        check("post_reset_underflow", uf0, 1);
        check("post_reset_level", lv0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
